serial_word_assembler: RTL

SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

---
 rtl/serial_word_assembler_if.sv | 20 ++
 rtl/serial_word_assembler.sv | 86 ++++++++
 2 files changed

// File: rtl/serial_word_assembler_if.sv
// serial_word_assembler_if: serial bit input and assembled-word output bundle.
// perr exists only when PARITY_CHECK_EN is defined.
interface serial_word_assembler_if #(parameter int N = 4);
  logic sin;
  logic sin_valid;
  logic clr;
  logic ready;
  logic [N-1:0] D;
  logic L;
  logic busy;
  logic [5:0] cnt;
`ifdef PARITY_CHECK_EN
  logic perr;
  modport master(output sin, sin_valid, clr, input ready, D, L, busy, cnt, perr);
  modport slave(input sin, sin_valid, clr, output ready, D, L, busy, cnt, perr);
`else
  modport master(output sin, sin_valid, clr, input ready, D, L, busy, cnt);
  modport slave(input sin, sin_valid, clr, output ready, D, L, busy, cnt);
`endif
endinterface

// File: rtl/serial_word_assembler.sv
// serial_word_assembler: MSB-first serial-to-parallel word builder with one-cycle load strobe.
// Optional trailing even-parity bit and perr output when PARITY_CHECK_EN is defined.
module serial_word_assembler #(
  parameter int N = 4
) (
  input logic clock,
  input logic R_n,
  serial_word_assembler_if.slave bus
);
`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
`endif
  state_t state, state_d;
  logic [N-1:0] d_q, d_d;
  logic [5:0] cnt_q, cnt_d;
  logic perr_q, perr_d;
  logic accept;
  logic [N-1:0] shifted;
  assign accept = bus.sin_valid && (state != LOAD) && !bus.clr;
  assign shifted = {d_q[N-2:0], bus.sin};
  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) begin
      state <= IDLE;
      d_q <= '0;
      cnt_q <= '0;
      perr_q <= 1'b0;
    end else begin
      state <= state_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      perr_q <= perr_d;
    end
  end
  // clr wins over everything, including a pending LOAD, and leaves D untouched
  always_comb begin
    state_d = state;
    d_d = d_q;
    cnt_d = cnt_q;
    perr_d = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          d_d = shifted;
          cnt_d = 6'd1;
          state_d = SHIFT;
        end
        SHIFT: if (accept) begin
          d_d = shifted;
          cnt_d = cnt_q + 6'd1;
`ifdef PARITY_CHECK_EN
          state_d = (cnt_q == 6'(N - 1)) ? PARITY : SHIFT;
`else
          state_d = (cnt_q == 6'(N - 1)) ? LOAD : SHIFT;
`endif
        end
`ifdef PARITY_CHECK_EN
        PARITY: if (accept) begin
          perr_d = ^d_q ^ bus.sin;
          state_d = perr_d ? IDLE : LOAD;
          cnt_d = perr_d ? 6'd0 : cnt_q;
        end
`endif
        LOAD: begin
          state_d = IDLE;
          cnt_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign bus.ready = state != LOAD;
  assign bus.L = (state == LOAD) && !bus.clr;
  assign bus.D = d_q;
  assign bus.cnt = cnt_q;
`ifdef PARITY_CHECK_EN
  assign bus.busy = (state == SHIFT) || (state == PARITY);
  assign bus.perr = perr_q;
`else
  assign bus.busy = state == SHIFT;
`endif
endmodule
